// File: rtl/joust2_pkg.sv
// Shared definitions for the Joust 2 ROM loader: region map, expected image
// length, loader state encoding and the beat record carried through the FIFO.
package joust2_pkg;

  localparam logic [17:0] R0_SIZE = 18'h10000;  // main program
  localparam logic [17:0] R1_SIZE = 18'h04000;  // sound
  localparam logic [17:0] R2_SIZE = 18'h08000;  // graphics
  localparam logic [17:0] R3_SIZE = 18'h04000;  // speech

  localparam logic [17:0] R0_BASE  = 18'h00000;
  localparam logic [17:0] R1_BASE  = R0_BASE + R0_SIZE;
  localparam logic [17:0] R2_BASE  = R1_BASE + R1_SIZE;
  localparam logic [17:0] R3_BASE  = R2_BASE + R2_SIZE;
  localparam logic [17:0] LOAD_LEN = R3_BASE + R3_SIZE;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_DRAIN,
    ST_HOLD,
    ST_RUN
  } load_state_t;

  typedef struct packed {
    logic [3:0]  we;
    logic [15:0] addr;
    logic [7:0]  data;
  } rom_beat_t;

  localparam int unsigned BEAT_W = $bits(rom_beat_t);

  function automatic rom_beat_t decode_beat(input logic [16:0] addr, input logic [7:0] data);
    rom_beat_t   beat;
    logic [17:0] full_addr;
    full_addr = {1'b0, addr};
    beat.data = data;
    if (full_addr < R1_BASE) begin
      beat.we   = 4'b0001;
      beat.addr = 16'(full_addr - R0_BASE);
    end else if (full_addr < R2_BASE) begin
      beat.we   = 4'b0010;
      beat.addr = 16'(full_addr - R1_BASE);
    end else if (full_addr < R3_BASE) begin
      beat.we   = 4'b0100;
      beat.addr = 16'(full_addr - R2_BASE);
    end else begin
      beat.we   = 4'b1000;
      beat.addr = 16'(full_addr - R3_BASE);
    end
    return beat;
  endfunction

endpackage

// File: rtl/rom_beat_fifo.sv
// Two-entry beat FIFO between the HPS download stream and the ROM sink.
// slot0 is always the head; simultaneous push and pop keep occupancy.
module rom_beat_fifo #(
  parameter int unsigned WIDTH = 28
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] in_data,
  output logic [WIDTH-1:0] head,
  output logic             full,
  output logic             empty
);

  logic [WIDTH-1:0] slot0;
  logic [WIDTH-1:0] slot1;
  logic [1:0]       count;
  logic             do_push;
  logic             do_pop;

  assign do_pop  = pop && (count != 2'd0);
  assign do_push = push && ((count != 2'd2) || do_pop);

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      slot0 <= '0;
      slot1 <= '0;
      count <= '0;
    end else begin
      case ({do_push, do_pop})
        2'b11: begin
          if (count == 2'd1) begin
            slot0 <= in_data;
          end else begin
            slot0 <= slot1;
            slot1 <= in_data;
          end
        end
        2'b01: begin
          slot0 <= slot1;
          count <= count - 2'd1;
        end
        2'b10: begin
          if (count == 2'd0) slot0 <= in_data;
          else               slot1 <= in_data;
          count <= count + 2'd1;
        end
        default: ;
      endcase
    end
  end

  assign head  = slot0;
  assign full  = (count == 2'd2);
  assign empty = (count == 2'd0);

endmodule

// File: rtl/joust2_rom_loader.sv
// Joust 2 ROM loader: decodes the HPS download into four ROM regions, buffers
// beats for a stalling sink, checks length and holds the core in reset.
module joust2_rom_loader
  import joust2_pkg::*;
#(
  parameter int unsigned HOLD_CYCLES = 16
) (
  input  logic        clk_sys,
  input  logic        reset_n,
  input  logic        ioctl_download,
  input  logic        ioctl_wr,
  input  logic [7:0]  ioctl_index,
  input  logic [16:0] ioctl_addr,
  input  logic [7:0]  ioctl_dout,
  output logic        ioctl_wait,
  output logic [3:0]  rom_we,
  output logic [15:0] rom_addr,
  output logic [7:0]  rom_data,
  input  logic        rom_ready,
  output logic        core_reset_n,
  output logic        load_done,
  output logic        load_err,
  output logic [7:0]  load_sum
);

  load_state_t state;
  logic        download_q;
  logic [17:0] beat_cnt;
  logic [15:0] hold_cnt;
  logic        dl_start;
  logic        beat_valid;
  logic        overrun;
  logic        fifo_drop;
  logic        push;
  logic        pop;
  logic        full;
  logic        empty;
  rom_beat_t   in_beat;
  rom_beat_t   head;

  assign dl_start   = ioctl_download && !download_q && (ioctl_index == 8'd0);
  assign beat_valid = (state == ST_LOAD) && ioctl_download && ioctl_wr && (ioctl_index == 8'd0);
  assign overrun    = beat_valid && (beat_cnt == LOAD_LEN);
  assign pop        = rom_ready && !empty;
  // A full FIFO still takes a beat when the head leaves in the same cycle.
  assign fifo_drop  = beat_valid && !overrun && full && !pop;
  assign push       = beat_valid && !overrun && !fifo_drop;
  assign in_beat    = decode_beat(ioctl_addr, ioctl_dout);

  rom_beat_fifo #(.WIDTH(BEAT_W)) u_fifo (
    .clk     (clk_sys),
    .reset_n (reset_n),
    .push    (push),
    .pop     (pop),
    .in_data (in_beat),
    .head    (head),
    .full    (full),
    .empty   (empty)
  );

  assign rom_we     = empty ? '0 : head.we;
  assign rom_addr   = empty ? '0 : head.addr;
  assign rom_data   = empty ? '0 : head.data;
  assign ioctl_wait = full;

  always_ff @(posedge clk_sys) begin
    if (!reset_n) begin
      state        <= ST_IDLE;
      download_q   <= 1'b1;  // a download already active at reset must restart
      beat_cnt     <= '0;
      hold_cnt     <= '0;
      core_reset_n <= 1'b0;
      load_done    <= 1'b0;
      load_err     <= 1'b0;
      load_sum     <= '0;
    end else begin
      download_q <= ioctl_download;
      if (push) begin
        beat_cnt <= beat_cnt + 18'd1;
        load_sum <= load_sum + ioctl_dout;
      end
      if (overrun || fifo_drop) load_err <= 1'b1;

      case (state)
        ST_IDLE, ST_RUN: begin
          if (dl_start) begin
            state        <= ST_LOAD;
            beat_cnt     <= '0;
            load_sum     <= '0;
            load_err     <= 1'b0;
            load_done    <= 1'b0;
            core_reset_n <= 1'b0;
          end
        end
        ST_LOAD: begin
          if (!ioctl_download) state <= ST_DRAIN;
        end
        ST_DRAIN: begin
          if (empty) begin
            if ((beat_cnt == LOAD_LEN) && !load_err) begin
              // The first empty cycle counts as the first reset-hold cycle.
              if (HOLD_CYCLES <= 1) begin
                state        <= ST_RUN;
                core_reset_n <= 1'b1;
                load_done    <= 1'b1;
              end else begin
                state    <= ST_HOLD;
                hold_cnt <= 16'd1;
              end
            end else begin
              load_err <= 1'b1;
              state    <= ST_IDLE;
            end
          end
        end
        ST_HOLD: begin
          if (hold_cnt >= 16'(HOLD_CYCLES - 1)) begin
            state        <= ST_RUN;
            core_reset_n <= 1'b1;
            load_done    <= 1'b1;
          end else begin
            hold_cnt <= hold_cnt + 16'd1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
